ncl_fp_sequencer: RTL and testbench
===================================

Name: ncl_fp_sequencer

Overview:
- Clocked controller that sequences one dual-rail, four-phase (ENC "FP", return-to-null) NCL pipeline built from TH_XY threshold gates.
- Accepts single-rail words on a valid/ready interface and encodes each into a DATA wavefront followed by a NULL wavefront.
- Tracks the stage's completion/acknowledge signals and decodes the output DATA wavefront back to single-rail with valid/ready.
- Used as the bench/SoC-side bridge and watchdog for async datapaths.

Parameters:
- W, 4, data width in single-rail bits; dual-rail buses are 2*W.
- TIMEOUT, 1023, maximum cycles allowed in any wait state before the error trap.
- SYNC_STAGES, 2, flop depth of synchronizers on ncl_ko and each ncl_out bit (minimum 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  input word valid.
- s_ready  out  1  sequencer can accept a word.
- s_data  in  W  input word.
- ncl_in  out  2W  dual-rail to stage; bit i: rail0 at [2i], rail1 at [2i+1]; all-zero = NULL.
- ncl_ko  in  1  stage input completion: 1 = request-for-data, 0 = request-for-null (async).
- ncl_out  in  2W  dual-rail from stage, same packing (async).
- ncl_ki  out  1  ack to stage output: 1 = request-for-data, 0 = request-for-null.
- m_valid  out  1  decoded result valid.
- m_ready  in  1  result consumer ready.
- m_data  out  W  decoded result.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky error (timeout or illegal encoding).

Behaviour:
- All logic on rising clk. On rst=1: state=IDLE, ncl_in=0, ncl_ki=1, s_ready=0, m_valid=0, m_data=0, busy=0, err=0. Synchronizer flops clear to 0. rst mid-transaction aborts immediately to these values; a wavefront in flight is not tracked.
- Completion decode uses synchronized values only. out_data = every bit pair has exactly one rail high. out_null = all 2W rails low. illegal = any pair 11.
- States and transitions:
  - IDLE: s_ready = ko_s & out_null. On s_valid & s_ready, register the DATA encoding of s_data (bit=1 -> 10 on rail1/rail0, bit=0 -> 01) onto ncl_in, then go to WAIT_DATA. ncl_in changes exactly one cycle after the handshake.
  - WAIT_DATA: hold ncl_in. When ko_s==0 and out_data, capture m_data (rail1 of each pair), set m_valid=1, go to HOLD.
  - HOLD: hold m_valid/m_data until m_ready; m_valid is never dropped without a handshake. On the handshake cycle, next cycle: m_valid=0, ncl_ki=0, ncl_in=0 (NULL), go to WAIT_NULL.
  - WAIT_NULL: when ko_s==1 and out_null, set ncl_ki=1 and go to IDLE. s_ready can rise the cycle after IDLE is entered.
  - ERR: ncl_in=0, ncl_ki=1, s_ready=0, m_valid=0, err=1. Exited only by rst.
- Simultaneous conditions: in WAIT_DATA, ko_s falling and out_data may occur in the same or different cycles; both are required and order is irrelevant. The same applies in WAIT_NULL.
- Watchdog: a counter clears on entry to WAIT_DATA or WAIT_NULL and increments every cycle in those states. Reaching TIMEOUT goes to ERR. HOLD is not timed, because backpressure is legal. The counter saturates and never wraps; width is clog2(TIMEOUT+1).
- illegal observed in any state other than ERR goes to ERR on the next cycle, with priority over every other transition.
- ncl_in and ncl_ki are driven directly from flops (glitch-free into the async domain). Per transaction, ncl_in goes from NULL to DATA exactly once and from DATA to NULL exactly once, so every rail is monotonic.
- Throughput: one word per full four-phase cycle. No pipelining of successive words.

Test Plan:
- Bench model: a single NCL buffer stage with about 30 ns rail delay; ko = NOT(output complete), ki gates the output. Reset 10 cycles, then s_data=4'hA -> ncl_in=8'b10011001 one cycle after the handshake; m_valid rises with m_data=4'hA; after m_ready, ncl_in=0 and ncl_ki=0, then ncl_ki returns to 1 and s_ready=1.
- Back-to-back words 0x0, 0xF, 0x5 with m_ready held high -> m_data sequence 0x0, 0xF, 0x5; the bench checker shows ncl_in alternating DATA/NULL with no DATA-to-DATA transition.
- Hold m_ready=0 for 500 cycles with a word pending -> m_valid and m_data stable, err=0, ncl_in unchanged.
- Stage model stuck with ko=1 after DATA -> err=1 exactly TIMEOUT cycles after WAIT_DATA entry; ncl_in=0, s_ready=0 until rst.
- Force ncl_out pair 0 to 11 during WAIT_DATA -> err=1 within SYNC_STAGES+1 cycles; state ERR.
- Assert rst in WAIT_NULL -> next cycle all outputs at reset values; a subsequent word 0x3 completes normally with m_data=0x3.

Source files
------------

// File: rtl/ncl_fp_sequencer.sv
// ncl_fp_sequencer: clocked bridge and watchdog for one four-phase
// dual-rail NCL stage, moving single-rail words over valid/ready.
module ncl_fp_sequencer #(
    parameter int W           = 4,
    parameter int TIMEOUT     = 1023,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W-1:0]   s_data,
    output logic [2*W-1:0] ncl_in,
    input  logic           ncl_ko,
    input  logic [2*W-1:0] ncl_out,
    output logic           ncl_ki,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [W-1:0]   m_data,
    output logic           busy,
    output logic           err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CMAX = '1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WD   = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_WN   = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]       state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic [SYNC_STAGES-1:0] ko_sync;
    logic [2*W-1:0]   out_sync [SYNC_STAGES];
    logic             ko_s;
    logic [2*W-1:0]   out_s;
    logic             out_data;
    logic             out_null;
    logic             illegal;
    logic [W-1:0]     out_val;
    logic [2*W-1:0]   enc;
    logic             wd_done;
    logic             wn_done;
    logic             timed;
    logic             to_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            ko_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++)
                out_sync[i] <= '0;
        end else begin
            ko_sync     <= {ko_sync[SYNC_STAGES-2:0], ncl_ko};
            out_sync[0] <= ncl_out;
            for (int i = 1; i < SYNC_STAGES; i++)
                out_sync[i] <= out_sync[i-1];
        end
    end

    assign ko_s  = ko_sync[SYNC_STAGES-1];
    assign out_s = out_sync[SYNC_STAGES-1];

    always_comb begin
        out_data = 1'b1;
        illegal  = 1'b0;
        out_val  = '0;
        enc      = '0;
        for (int i = 0; i < W; i++) begin
            if (out_s[2*i] == out_s[2*i+1])
                out_data = 1'b0;
            if (out_s[2*i] & out_s[2*i+1])
                illegal = 1'b1;
            out_val[i]   = out_s[2*i+1];
            enc[2*i]     = ~s_data[i];
            enc[2*i+1]   = s_data[i];
        end
    end

    assign out_null = (out_s == '0);
    assign cnt_nx   = (cnt == CMAX) ? cnt : cnt + 1'b1;
    assign timed    = (cnt_nx >= TMO);
    assign wd_done  = ~ko_s & out_data;
    assign wn_done  = ko_s & out_null;

    // an illegal pair outranks completion; completion outranks the watchdog
    assign to_err = (state != S_ERR)
                  & (illegal
                  | ((state == S_WD) & ~wd_done & timed)
                  | ((state == S_WN) & ~wn_done & timed));

    assign s_ready = (state == S_IDLE) & ko_s & out_null;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ncl_in  <= '0;
            ncl_ki  <= 1'b1;
            m_valid <= 1'b0;
            m_data  <= '0;
            err     <= 1'b0;
            cnt     <= '0;
        end else if (to_err) begin
            state   <= S_ERR;
            ncl_in  <= '0;
            ncl_ki  <= 1'b1;
            m_valid <= 1'b0;
            err     <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (s_valid && s_ready) begin
                        ncl_in <= enc;
                        cnt    <= '0;
                        state  <= S_WD;
                    end
                end
                S_WD: begin
                    cnt <= cnt_nx;
                    if (wd_done) begin
                        m_data  <= out_val;
                        m_valid <= 1'b1;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        ncl_ki  <= 1'b0;
                        ncl_in  <= '0;
                        cnt     <= '0;
                        state   <= S_WN;
                    end
                end
                S_WN: begin
                    cnt <= cnt_nx;
                    if (wn_done) begin
                        ncl_ki <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ncl_fp_sequencer.sv
// tb_ncl_fp_sequencer: scoreboard bench driving the sequencer against
// a behavioural NCL buffer stage with a three-cycle rail delay.
module tb_ncl_fp_sequencer;
    localparam int W   = 4;
    localparam int TMO = 1023;
    localparam int SS  = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [W-1:0]   s_data = '0;
    logic [2*W-1:0] ncl_in;
    logic           ncl_ko;
    logic [2*W-1:0] ncl_out;
    logic           ncl_ki;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [W-1:0]   m_data;
    logic           busy;
    logic           err;

    int total = 0;
    int bad   = 0;

    ncl_fp_sequencer #(.W(W), .TIMEOUT(TMO), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .ncl_in(ncl_in), .ncl_ko(ncl_ko), .ncl_out(ncl_out), .ncl_ki(ncl_ki),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // stage model: delayed C-element rails gated by ki, ko with hysteresis
    logic [2*W-1:0] in_d [3];
    logic           ki_d [3];
    logic [2*W-1:0] stage_q = '0;
    logic           ko_m = 1'b1;
    logic           stuck = 1'b0;
    logic           force_bad = 1'b0;

    function automatic logic all_data(input logic [2*W-1:0] v);
        logic r;
        r = 1'b1;
        for (int i = 0; i < W; i++)
            if (v[2*i] == v[2*i+1]) r = 1'b0;
        return r;
    endfunction

    function automatic logic [2*W-1:0] encode(input logic [W-1:0] d);
        logic [2*W-1:0] e;
        for (int i = 0; i < W; i++) begin
            e[2*i]   = ~d[i];
            e[2*i+1] = d[i];
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                in_d[i] <= '0;
                ki_d[i] <= 1'b1;
            end
            stage_q <= '0;
            ko_m    <= 1'b1;
        end else begin
            in_d[0] <= ncl_in;
            in_d[1] <= in_d[0];
            in_d[2] <= in_d[1];
            ki_d[0] <= ncl_ki;
            ki_d[1] <= ki_d[0];
            ki_d[2] <= ki_d[1];
            for (int r = 0; r < 2*W; r++) begin
                if (in_d[2][r] && ki_d[2])
                    stage_q[r] <= 1'b1;
                else if (!in_d[2][r] && !ki_d[2])
                    stage_q[r] <= 1'b0;
            end
            if (stage_q == '0)
                ko_m <= 1'b1;
            else if (all_data(stage_q))
                ko_m <= 1'b0;
        end
    end

    assign ncl_ko  = stuck ? 1'b1 : ko_m;
    assign ncl_out = stage_q | (force_bad ? 8'h03 : 8'h00);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [W-1:0]   sbq [$];
    logic [2*W-1:0] enc_exp = '0;
    logic           enc_pend = 1'b0;
    logic [2*W-1:0] prev_in = '0;

    always @(negedge clk) begin
        if (rst) begin
            enc_pend = 1'b0;
            prev_in  = ncl_in;
        end else begin
            if (enc_pend)
                chk("enc", ncl_in, enc_exp);
            enc_pend = 1'b0;
            if (ncl_in !== prev_in)
                chk("mono", (prev_in == '0) || (ncl_in == '0), 1);
            prev_in = ncl_in;
            if (s_valid && s_ready) begin
                sbq.push_back(s_data);
                enc_exp  = encode(s_data);
                enc_pend = 1'b1;
            end
            if (m_valid && m_ready) begin
                if (sbq.size() == 0)
                    chk("sb_extra", m_data, 32'hdead);
                else
                    chk("m_data", m_data, sbq.pop_front());
            end
        end
    end

    function automatic logic cond(input int sel);
        case (sel)
            0: return m_valid;
            1: return !ncl_ki;
            2: return ncl_ki;
            3: return s_ready;
            default: return sbq.size() == 0;
        endcase
    endfunction

    task automatic wait_on(input string tag, input int sel, input int lim);
        int  n;
        logic c;
        n = 0;
        c = cond(sel);
        while (!c && n < lim) begin
            @(posedge clk); #1;
            n++;
            c = cond(sel);
        end
        chk(tag, c, 1);
    endtask

    task automatic send(input logic [W-1:0] w);
        int n;
        n = 0;
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_rdy", s_ready, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in"},    ncl_in,  0);
        chk({tag, "_ki"},    ncl_ki,  1);
        chk({tag, "_rdy"},   s_ready, 0);
        chk({tag, "_mv"},    m_valid, 0);
        chk({tag, "_md"},    m_data,  0);
        chk({tag, "_busy"},  busy,    0);
        chk({tag, "_err"},   err,     0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [2*W-1:0] hold_in;
        int k;

        repeat (10) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst = 1'b0;

        m_ready = 1'b1;
        send(4'hA);
        chk("a_enc", ncl_in, 8'b10011001);
        wait_on("a_mvalid", 0, 100);
        wait_on("a_kilow", 1, 100);
        chk("a_null_in", ncl_in, 0);
        chk("a_null_mv", m_valid, 0);
        wait_on("a_kihigh", 2, 100);
        wait_on("a_rdy", 3, 100);

        send(4'h0);
        send(4'hF);
        send(4'h5);
        wait_on("b2b_drain", 4, 200);
        wait_on("b2b_rdy", 3, 100);

        m_ready = 1'b0;
        send(4'h6);
        wait_on("hold_mv", 0, 100);
        hold_in = ncl_in;
        for (int i = 0; i < 5; i++) begin
            repeat (100) @(posedge clk);
            #1;
            chk("hold_mv", m_valid, 1);
            chk("hold_md", m_data, 4'h6);
            chk("hold_err", err, 0);
            chk("hold_in", ncl_in, hold_in);
        end
        m_ready = 1'b1;
        wait_on("hold_drain", 4, 100);
        wait_on("hold_rdy", 3, 100);

        stuck = 1'b1;
        send(4'h9);
        k = 0;
        while (!err && k < TMO + 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("tmo_cyc", k, TMO);
        chk("tmo_in", ncl_in, 0);
        chk("tmo_rdy", s_ready, 0);
        chk("tmo_busy", busy, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("tmo_sticky", err, 1);
        chk("tmo_rdy2", s_ready, 0);
        sbq.delete();
        stuck = 1'b0;
        pulse_rst();
        chk("tmo_clr", err, 0);
        wait_on("tmo_rec_rdy", 3, 100);

        send(4'h2);
        force_bad = 1'b1;
        k = 0;
        while (!err && k < SS + 10) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ill_err", err, 1);
        chk("ill_lat", k <= SS + 1, 1);
        chk("ill_in", ncl_in, 0);
        chk("ill_busy", busy, 1);
        chk("ill_ki", ncl_ki, 1);
        sbq.delete();
        force_bad = 1'b0;
        pulse_rst();
        wait_on("ill_rec_rdy", 3, 100);

        m_ready = 1'b1;
        send(4'hC);
        wait_on("wn_kilow", 1, 100);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("wnrst");
        rst = 1'b0;
        send(4'h3);
        wait_on("post_drain", 4, 200);
        wait_on("post_rdy", 3, 100);

        chk("sb_left", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
